// File: rtl/parallax_layer_sched.sv
// Frame-level scheduler for the parallax star/mountain layers:
// per-pixel advance enables, reload strobes and time-shared scroll updates.
module parallax_layer_sched #(
  parameter int LAYERS     = 3,
  parameter int FIELD_BITS = 8,
  parameter int SPEED_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_layer,
  input  logic [SPEED_W-1:0]    cfg_speed,
  input  logic                  pause,
  input  logic                  step,
  output logic [LAYERS-1:0]     layer_en,
  output logic [LAYERS-1:0]     layer_load,
  output logic [LAYERS*8-1:0]   scroll_x,
  output logic [7:0]            frame_cnt,
  output logic                  busy
);

  typedef enum logic {RUN, UPD} state_t;

  state_t               state;
  logic [1:0]           idx;
  logic                 adv;
  logic                 step_pending;
  logic                 step_q;
  logic [7:0]           scroll [LAYERS];
  logic [SPEED_W-1:0]   live   [LAYERS];
  logic [SPEED_W-1:0]   shadow [LAYERS];

  logic                 in_field;
  logic                 frame_start;
  logic                 step_rise;
  logic                 cfg_fire;
  logic [2:0]           en_all;
  logic [7:0]           cur_scroll;
  logic [SPEED_W-1:0]   cur_speed;
  logic [7:0]           sum;

  assign in_field    = ((hpos >> FIELD_BITS) == 10'd0) &&
                       ((vpos >> FIELD_BITS) == 10'd0);
  assign frame_start = (hpos == 10'd0) && (vpos == 10'd0);
  assign step_rise   = step & ~step_q & pause;
  assign cfg_ready   = ~busy;
  assign cfg_fire    = cfg_valid & cfg_ready;

  // Layer i advances every 2^i pixels: deeper layers drift slower.
  assign en_all   = {~hpos[0] & ~hpos[1], ~hpos[0], 1'b1};
  assign layer_en = (in_field && !busy) ? en_all[LAYERS-1:0] : '0;

  for (genvar g = 0; g < LAYERS; g++) begin : g_pack
    assign scroll_x[8*g +: 8] = scroll[g];
  end

  // Single adder shared by all layers, selected by the update index.
  always_comb begin
    cur_scroll = '0;
    cur_speed  = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (idx == 2'(i)) begin
        cur_scroll = scroll[i];
        cur_speed  = live[i];
      end
    end
    sum = cur_scroll + 8'(cur_speed);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      idx          <= '0;
      adv          <= 1'b0;
      busy         <= 1'b0;
      frame_cnt    <= '0;
      layer_load   <= '0;
      step_pending <= 1'b0;
      step_q       <= 1'b0;
      for (int i = 0; i < LAYERS; i++) begin
        scroll[i] <= '0;
        live[i]   <= SPEED_W'(i + 1);
        shadow[i] <= SPEED_W'(i + 1);
      end
    end else begin
      step_q     <= step;
      layer_load <= '0;
      for (int i = 0; i < LAYERS; i++) begin
        if (cfg_fire && cfg_layer == 2'(i))
          shadow[i] <= cfg_speed;
      end
      unique case (state)
        RUN: begin
          if (frame_start) begin
            state        <= UPD;
            idx          <= '0;
            busy         <= 1'b1;
            frame_cnt    <= frame_cnt + 8'd1;
            adv          <= ~pause | step_pending;
            step_pending <= 1'b0;
            layer_load   <= LAYERS'(1);
            for (int i = 0; i < LAYERS; i++)
              live[i] <= shadow[i];
          end
        end
        UPD: begin
          for (int i = 0; i < LAYERS; i++) begin
            if (adv && idx == 2'(i))
              scroll[i] <= sum;
          end
          if (idx == 2'(LAYERS - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            idx        <= idx + 2'd1;
            layer_load <= LAYERS'(1) << (idx + 2'd1);
          end
        end
        default: state <= RUN;
      endcase
      // A step arriving on a frame entry is kept for the following frame.
      if (step_rise)
        step_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parallax_layer_sched.sv
// Bench for parallax_layer_sched: enable table, directed frame
// sequences and randomized frames against a frame-level model.
module tb_parallax_layer_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_layer;
  logic [3:0]  cfg_speed;
  logic        pause, step;
  logic [2:0]  layer_en, layer_load;
  logic [23:0] scroll_x;
  logic [7:0]  frame_cnt;
  logic        busy;

  parallax_layer_sched #(.LAYERS(3), .FIELD_BITS(8), .SPEED_W(4)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_layer(cfg_layer), .cfg_speed(cfg_speed),
    .pause(pause), .step(step),
    .layer_en(layer_en), .layer_load(layer_load),
    .scroll_x(scroll_x), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_scroll [3];
  int m_live   [3];
  int m_shadow [3];
  int m_fc;
  bit m_pend;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] en;
  } en_vec_t;

  en_vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_scroll[i] = 0;
      m_live[i]   = i + 1;
      m_shadow[i] = i + 1;
    end
    m_fc   = 0;
    m_pend = 0;
  endfunction

  function automatic void model_frame(input bit paused);
    bit a;
    a = !paused || m_pend;
    m_pend = 0;
    m_fc = (m_fc + 1) % 256;
    for (int i = 0; i < 3; i++) begin
      m_live[i] = m_shadow[i];
      if (a) m_scroll[i] = (m_scroll[i] + m_live[i]) % 256;
    end
  endfunction

  function automatic void model_cfg(input int l, input int s);
    if (l < 3) m_shadow[l] = s;
  endfunction

  function automatic logic [23:0] m_pack();
    return {8'(m_scroll[2]), 8'(m_scroll[1]), 8'(m_scroll[0])};
  endfunction

  function automatic logic [2:0] m_en(input logic [9:0] h,
                                      input logic [9:0] v);
    if (h >= 256 || v >= 256) return 3'b000;
    return {!h[0] && !h[1], !h[0], 1'b1};
  endfunction

  task automatic reset_check(input string tag);
    reset = 1'b1;
    cyc();
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_load"}, 32'(layer_load), 0);
    chk({tag, "_scroll"}, 32'(scroll_x), 0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
    chk({tag, "_ready"}, 32'(cfg_ready), 1);
    chk({tag, "_en"}, 32'(layer_en), 0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input logic [1:0] l, input logic [3:0] s);
    chk("cfg_ready_idle", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_layer = l;
    cfg_speed = s;
    cyc();
    cfg_valid = 1'b0;
    model_cfg(int'(l), int'(s));
  endtask

  task automatic pulse_step();
    step = 1'b1;
    if (pause) m_pend = 1;
    cyc();
    step = 1'b0;
    cyc();
  endtask

  task automatic do_frame(input bit wr, input logic [1:0] l,
                          input logic [3:0] s);
    hpos = 10'd0;
    vpos = 10'd0;
    if (wr) begin
      cfg_valid = 1'b1;
      cfg_layer = l;
      cfg_speed = s;
    end
    model_frame(pause);
    if (wr) model_cfg(int'(l), int'(s));
    cyc();
    cfg_valid = 1'b0;
    hpos = 10'd4;
    vpos = 10'd5;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("win_busy", 32'(busy), 1);
      chk("win_load", 32'(layer_load), 32'(3'b001 << k));
      chk("win_ready", 32'(cfg_ready), 0);
      chk("win_en_gated", 32'(layer_en), 0);
      cyc();
    end
    chk("end_busy", 32'(busy), 0);
    chk("end_load", 32'(layer_load), 0);
    chk("end_scroll", 32'(scroll_x), 32'(m_pack()));
    chk("end_fcnt", 32'(frame_cnt), 32'(m_fc));
    chk("end_en", 32'(layer_en), 32'(3'b111));
    hpos = 10'd300;
    vpos = 10'd300;
  endtask

  initial begin
    reset = 1'b1;
    hpos = 10'd300;
    vpos = 10'd300;
    cfg_valid = 1'b0;
    cfg_layer = 2'd0;
    cfg_speed = 4'd0;
    pause = 1'b0;
    step = 1'b0;
    cyc();
    reset_check("rst");

    tbl[0] = '{10'd4,   10'd5,   3'b111};
    tbl[1] = '{10'd5,   10'd5,   3'b001};
    tbl[2] = '{10'd6,   10'd5,   3'b011};
    tbl[3] = '{10'd256, 10'd5,   3'b000};
    tbl[4] = '{10'd7,   10'd5,   3'b001};
    tbl[5] = '{10'd0,   10'd256, 3'b000};
    tbl[6] = '{10'd4,   10'd256, 3'b000};
    tbl[7] = '{10'd255, 10'd255, 3'b001};
    tbl[8] = '{10'd252, 10'd255, 3'b111};
    tbl[9] = '{10'd8,   10'd0,   3'b111};
    for (int i = 0; i < 10; i++) begin
      hpos = tbl[i].h;
      vpos = tbl[i].v;
      #1;
      chk("en_table", 32'(layer_en), 32'(tbl[i].en));
    end
    hpos = 10'd300;
    vpos = 10'd300;

    do_frame(0, 0, 0);
    chk("first_scroll", 32'(scroll_x), 32'h030201);
    chk("first_fcnt", 32'(frame_cnt), 1);

    cfg_write(2'd1, 4'd9);
    do_frame(0, 0, 0);
    chk("l1_after1", 32'(scroll_x[15:8]), 11);
    do_frame(0, 0, 0);
    chk("l1_after2", 32'(scroll_x[15:8]), 20);

    do_frame(1, 2'd0, 4'd5);
    do_frame(0, 0, 0);
    chk("samecyc_cfg", 32'(scroll_x), 32'h0f2609);

    cfg_write(2'd3, 4'd15);
    do_frame(0, 0, 0);
    chk("cfg_layer3", 32'(scroll_x), 32'h122f0e);

    pause = 1'b1;
    for (int i = 0; i < 3; i++) do_frame(0, 0, 0);
    chk("pause_frozen", 32'(scroll_x), 32'h122f0e);
    chk("pause_fcnt", 32'(frame_cnt), 9);
    pulse_step();
    pulse_step();
    do_frame(0, 0, 0);
    chk("step_once", 32'(scroll_x), 32'h153813);
    do_frame(0, 0, 0);
    chk("step_consumed", 32'(scroll_x), 32'h153813);
    pause = 1'b0;

    cfg_write(2'd2, 4'd15);
    for (int i = 0; i < 15; i++) do_frame(0, 0, 0);
    cfg_write(2'd2, 4'd4);
    do_frame(0, 0, 0);
    chk("wrap_pre", 32'(scroll_x[23:16]), 250);
    cfg_write(2'd2, 4'd15);
    do_frame(0, 0, 0);
    chk("wrap_post", 32'(scroll_x[23:16]), 9);

    while (m_fc != 255) do_frame(0, 0, 0);
    chk("fcnt_255", 32'(frame_cnt), 255);
    do_frame(0, 0, 0);
    chk("fcnt_wrap", 32'(frame_cnt), 0);

    for (int it = 0; it < 150; it++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) begin
        hpos = 10'($urandom_range(0, 1023));
        vpos = 10'($urandom_range(0, 300));
        if (hpos == 10'd0 && vpos == 10'd0) hpos = 10'd1;
        #1;
        chk("rand_en", 32'(layer_en), 32'(m_en(hpos, vpos)));
        cyc();
      end
      hpos = 10'd300;
      vpos = 10'd300;
      if ($urandom_range(0, 3) == 0) pause = ~pause;
      n = int'($urandom_range(0, 2));
      for (int j = 0; j < n; j++)
        cfg_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      n = int'($urandom_range(0, 2));
      for (int j = 0; j < n; j++) pulse_step();
      do_frame(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)));
    end
    pause = 1'b0;

    hpos = 10'd0;
    vpos = 10'd0;
    cyc();
    hpos = 10'd300;
    vpos = 10'd300;
    cyc();
    chk("mid_upd_busy", 32'(busy), 1);
    reset_check("rst_mid");
    cyc();
    chk("post_rst_busy", 32'(busy), 0);
    do_frame(0, 0, 0);
    chk("post_rst_scroll", 32'(scroll_x), 32'h030201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parallax_layer_sched.md
Name: parallax_layer_sched

Overview:
- Frame-level controller for the LFSR-based parallax background.
- Sequences per-layer advance enables, seed-reload strobes and horizontal scroll offsets for up to 3 star/mountain layers.
- Time-shares one scroll adder across layers during a short post-frame-start update window.
- Takes pixel coordinates from the VGA sync generator. Accepts per-layer speed configuration over a valid/ready port, applied at frame boundaries only.

Parameters:
- LAYERS, 3, number of layers scheduled (1..3).
- FIELD_BITS, 8, side of the square star field in pixels = 2^FIELD_BITS (256).
- SPEED_W, 4, width of per-layer speed value (pixels/frame).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hpos  in  10  current pixel x from sync generator
- vpos  in  10  current pixel y from sync generator
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_layer  in  2  target layer index
- cfg_speed  in  SPEED_W  new speed for target layer
- pause  in  1  freeze scrolling (level)
- step  in  1  single-frame advance while paused (pulse)
- layer_en  out  LAYERS  per-pixel LFSR advance enable per layer
- layer_load  out  LAYERS  one-cycle seed/scroll reload strobe per layer
- scroll_x  out  LAYERS*8  packed scroll offsets, layer i at [8i+7:8i]
- frame_cnt  out  8  frames elapsed, wraps 255->0
- busy  out  1  high while update window runs

Behaviour:
- Reset: scroll_x=0, speeds: layer i = i+1, shadow speeds equal live speeds, frame_cnt=0, layer_en=0, layer_load=0, busy=0, cfg_ready=1, state=RUN, step_pending=0. Reset mid-update aborts the update; no partial scroll writes survive.
- in_field = hpos < 2^FIELD_BITS and vpos < 2^FIELD_BITS.
- Enables are combinational from hpos/vpos, gated by in_field and busy=0:
  - layer_en[0] = in_field.
  - layer_en[1] = in_field & !hpos[0].
  - layer_en[2] = in_field & !hpos[0] & !hpos[1].
  - Bits >= LAYERS are absent.
- frame_start = (hpos==0 && vpos==0), sampled each cycle.
- FSM states:
  - RUN: on frame_start go to UPD with idx=0, busy=1, frame_cnt+1, live speeds <= shadow speeds.
  - UPD: one layer per cycle.
    - layer_load[idx]=1 for exactly that cycle.
    - If advancing: scroll_x[idx] <= scroll_x[idx] + speed[idx], mod 256 via the shared adder. Otherwise scroll_x[idx] is unchanged; the load pulse still fires.
    - idx increments. After idx==LAYERS-1, return to RUN and set busy=0.
    - Window length is exactly LAYERS cycles: frame_start at cycle T gives busy high T+1..T+LAYERS, loads on T+1..T+LAYERS.
  - advancing = !pause | step_pending, latched on entry to UPD. step_pending is consumed (cleared) when a paused frame advances.
- step: a rising pulse while pause=1 sets step_pending. Multiple pulses within one frame collapse to one step. Step while pause=0 is ignored.
- Config handshake:
  - cfg_ready = !busy.
  - Transfer occurs when cfg_valid & cfg_ready and writes the shadow speed only. The new speed takes effect at the next frame_start, never mid-frame.
  - cfg_layer >= LAYERS: accepted and dropped.
  - Write on the same cycle as frame_start: the write lands in shadow, and the copy-to-live uses the OLD shadow value (write applies from the following frame).
- frame_start while busy (impossible with a real sync generator): ignored.
- scroll_x wraps 255+speed to (255+speed) mod 256 with no flag. Speed 0 gives a stationary layer with loads still pulsing.

Test Plan:
- Reset then one frame_start: busy high 3 cycles; layer_load = 001, 010, 100; scroll_x = {3,2,1}; frame_cnt=1; cfg_ready low during the window.
- Enables at vpos=5: hpos=4 -> layer_en=111; hpos=5 -> 001; hpos=6 -> 011; hpos=256 -> 000; vpos=256 -> 000 for all hpos.
- Config: write layer1 speed=9 mid-frame, then 2 frame_starts -> layer1 scroll 2->11->20. A write on the frame_start cycle applies one frame later. cfg_layer=3 does not change any scroll.
- Pause: pause=1 across 3 frames -> scroll_x frozen, loads still pulse, frame_cnt +3. Two step pulses in one frame -> exactly one advance of {+3,+2,+1}.
- Wrap: layer2 speed=15, scroll starting at 250 -> 9 next frame. Counter at 255 -> frame_cnt=0.
- Reset asserted in the 2nd update cycle -> all outputs at reset values next cycle and busy=0.
